// File: rtl/reg_file_reader_if.sv
// Element stream from reg_file_reader to its consumer.
// valid/ready handshake, with an optional last-element marker.
interface reg_file_reader_if #(
    parameter int N = 32
);
    logic [N-1:0] m_data;
    logic         m_valid;
    logic         m_ready;
    logic         m_last;

    modport master (
        output m_data,
        output m_valid,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/reg_file_reader.sv
// Burst reader: loads register-file entries and streams their elements one at a time.
// Define REG_FILE_READER_LAST_EN to generate m_last on the final element of a burst.
module reg_file_reader #(
    parameter int WIDTH_ADDR   = 4,
    parameter int WIDTH_VECTOR = 8,
    parameter int N            = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [WIDTH_ADDR-1:0]     base_addr,
    input  logic [WIDTH_ADDR:0]       count,
    output logic [WIDTH_ADDR-1:0]     rd_addr,
    input  logic [WIDTH_VECTOR*N-1:0] rd_data,
    reg_file_reader_if.master         stream,
    output logic                      busy,
    output logic                      done
);

    localparam int IDX_W = (WIDTH_VECTOR > 1) ? $clog2(WIDTH_VECTOR) : 1;
    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(WIDTH_VECTOR - 1);
    localparam logic [WIDTH_ADDR:0] ONE      = (WIDTH_ADDR + 1)'(1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        FIN
    } state_t;

    state_t                    state;
    state_t                    state_next;
    logic [WIDTH_ADDR-1:0]     entry_addr;
    logic [WIDTH_ADDR-1:0]     rd_addr_q;
    logic [WIDTH_ADDR:0]       remaining;
    logic [IDX_W-1:0]          index;
    logic [WIDTH_VECTOR*N-1:0] buffer;
    logic                      xfer;
    logic                      last_elem;

    assign xfer      = (state == SHIFT) && stream.m_ready;
    assign last_elem = (index == LAST_IDX);

    // The read port only follows the entry address during LOAD and holds it otherwise.
    assign rd_addr = (state == LOAD) ? entry_addr : rd_addr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry_addr <= '0;
            rd_addr_q  <= '0;
            remaining  <= '0;
            index      <= '0;
            buffer     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && (count != '0)) begin
                        entry_addr <= base_addr;
                        remaining  <= count;
                    end
                end
                LOAD: begin
                    rd_addr_q <= entry_addr;
                    buffer    <= rd_data;
                    index     <= '0;
                end
                SHIFT: begin
                    if (xfer) begin
                        if (last_elem) begin
                            remaining  <= remaining - 1'b1;
                            entry_addr <= entry_addr + 1'b1;
                            index      <= '0;
                        end else begin
                            index <= index + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        state_next     = state;
        busy           = 1'b0;
        done           = 1'b0;
        stream.m_valid = 1'b0;
        stream.m_data  = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (count != '0) ? LOAD : FIN;
                end
            end
            LOAD: begin
                busy       = 1'b1;
                state_next = SHIFT;
            end
            SHIFT: begin
                busy           = 1'b1;
                stream.m_valid = 1'b1;
                stream.m_data  = buffer[index*N +: N];
                if (xfer && last_elem) begin
                    state_next = (remaining != ONE) ? LOAD : FIN;
                end
            end
            FIN: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

`ifdef REG_FILE_READER_LAST_EN
    assign stream.m_last = (state == SHIFT) && last_elem && (remaining == ONE);
`else
    assign stream.m_last = 1'b0;
`endif

endmodule

// File: tb/tb_reg_file_reader.sv
// Bench for reg_file_reader: an expected element queue built from the register-file
// contents, compared against the stream each cycle, plus literal latency/data pins.
module tb_reg_file_reader;

    localparam int WA = 4;
    localparam int WC = WA + 1;
    localparam int WV = 8;
    localparam int N  = 32;
    localparam int ENTRIES = 1 << WA;

`ifdef REG_FILE_READER_LAST_EN
    localparam bit LAST_ON = 1'b1;
`else
    localparam bit LAST_ON = 1'b0;
`endif

    typedef struct packed {
        logic [WA-1:0] addr;
        logic          last;
        logic [N-1:0]  data;
    } elem_t;

    logic              clk;
    logic              rst;
    logic              start;
    logic [WA-1:0]     base_addr;
    logic [WA:0]       count;
    logic [WA-1:0]     rd_addr;
    logic [WV*N-1:0]   rd_data;
    logic              busy;
    logic              done;

    logic [WV*N-1:0]   mem [ENTRIES];
    elem_t             exp_q[$];
    elem_t             obs_q[$];
    int                checks = 0;
    int                errors = 0;
    int                ready_mode = 0;

    reg_file_reader_if #(.N(N)) stream ();

    reg_file_reader #(
        .WIDTH_ADDR  (WA),
        .WIDTH_VECTOR(WV),
        .N           (N)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .base_addr(base_addr),
        .count    (count),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .stream   (stream),
        .busy     (busy),
        .done     (done)
    );

    assign rd_data = mem[rd_addr];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // m_ready patterns: 0 = always ready, 1 = repeating 1,0,0,1, 2 = random.
    initial begin
        int phase;
        phase = 0;
        stream.m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1: begin
                    stream.m_ready = (phase % 4 == 0) || (phase % 4 == 3);
                    phase++;
                end
                2: stream.m_ready = 1'($urandom_range(0, 1));
                default: stream.m_ready = 1'b1;
            endcase
        end
    end

    // Stream checker: every valid cycle must show the head of the expected queue.
    initial begin
        bit            stalled;
        logic [N-1:0]  held;
        elem_t         o;
        stalled = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stalled = 1'b0;
            end else if (stream.m_valid) begin
                if (stalled) checkOutput("stall_stable", 64'(stream.m_data), 64'(held));
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_valid", 64'(1), 64'(0));
                end else begin
                    checkOutput("m_data", 64'(stream.m_data), 64'(exp_q[0].data));
                    checkOutput("m_last", 64'(stream.m_last), 64'(LAST_ON & exp_q[0].last));
                    checkOutput("rd_addr", 64'(rd_addr), 64'(exp_q[0].addr));
                    checkOutput("busy_streaming", 64'(busy), 64'(1));
                    if (stream.m_ready) begin
                        o.addr = rd_addr;
                        o.last = stream.m_last;
                        o.data = stream.m_data;
                        obs_q.push_back(o);
                        void'(exp_q.pop_front());
                    end
                end
                stalled = !stream.m_ready;
                held = stream.m_data;
            end else begin
                stalled = 1'b0;
            end
        end
    end

    task automatic pushExpected(input logic [WA-1:0] base, input logic [WA:0] cnt);
        elem_t e;
        int    a;
        for (int ent = 0; ent < int'(cnt); ent++) begin
            a = (int'(base) + ent) % ENTRIES;
            for (int i = 0; i < WV; i++) begin
                e.addr = WA'(a);
                e.last = (ent == int'(cnt) - 1) && (i == WV - 1);
                e.data = mem[a][i*N +: N];
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic applyStimulus(input logic [WA-1:0] base, input logic [WA:0] cnt,
                                 input bit timed, input bit mid_start);
        int k;
        int first_valid;
        bit got_done;
        @(posedge clk);
        #1;
        start = 1'b1;
        base_addr = base;
        count = cnt;
        pushExpected(base, cnt);
        @(posedge clk);
        #1;
        start = 1'b0;
        k = 0;
        first_valid = -1;
        got_done = 1'b0;
        while (!got_done && k < 3000) begin
            @(negedge clk);
            k++;
            if (stream.m_valid && first_valid < 0) first_valid = k;
            if (done) begin
                got_done = 1'b1;
            end else if (cnt != '0) begin
                checkOutput("busy_during_burst", 64'(busy), 64'(1));
            end
            if (mid_start && k == 4) begin
                #1;
                start = 1'b1;
                base_addr = base + WA'(5);
                count = WC'(3);
            end
            if (mid_start && k == 6) begin
                #1;
                start = 1'b0;
            end
        end
        start = 1'b0;
        checkOutput("done_seen", 64'(got_done), 64'(1));
        checkOutput("queue_drained", 64'(exp_q.size()), 64'(0));
        checkOutput("busy_at_done", 64'(busy), 64'(0));
        if (timed) begin
            checkOutput("done_latency", 64'(k), 64'((cnt == '0) ? 1 : 1 + 9 * int'(cnt)));
            if (cnt != '0) checkOutput("first_valid_latency", 64'(first_valid), 64'(2));
        end
        @(negedge clk);
        checkOutput("done_single_cycle", 64'(done), 64'(0));
        exp_q.delete();
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_m_valid"}, 64'(stream.m_valid), 64'(0));
        checkOutput({tag, "_m_data"},  64'(stream.m_data),  64'(0));
        checkOutput({tag, "_m_last"},  64'(stream.m_last),  64'(0));
        checkOutput({tag, "_busy"},    64'(busy),           64'(0));
        checkOutput({tag, "_done"},    64'(done),           64'(0));
        checkOutput({tag, "_rd_addr"}, 64'(rd_addr),        64'(0));
    endtask

    task automatic resetMidBurst();
        int k;
        ready_mode = 0;
        @(posedge clk);
        #1;
        start = 1'b1;
        base_addr = WA'(9);
        count = WC'(2);
        pushExpected(WA'(9), WC'(2));
        @(posedge clk);
        #1;
        start = 1'b0;
        k = 0;
        while (k < 6) begin
            @(negedge clk);
            k++;
        end
        #1;
        rst = 1'b1;
        #1;
        checkAllZero("async_reset");
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            checkOutput("no_done_after_reset", 64'(done), 64'(0));
            checkOutput("idle_after_reset", 64'(stream.m_valid), 64'(0));
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        base_addr = '0;
        count = '0;
        for (int a = 0; a < ENTRIES; a++)
            for (int i = 0; i < WV; i++)
                mem[a][i*N +: N] = $urandom();
        for (int i = 0; i < WV; i++) begin
            mem[3][i*N +: N]  = 32'h10 + 32'(i);
            mem[15][i*N +: N] = 32'hF0 + 32'(i);
            mem[0][i*N +: N]  = 32'hA0 + 32'(i);
        end
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        rst = 1'b0;
        $display("[TB] reset released");

        obs_q.delete();
        applyStimulus(WA'(3), WC'(1), 1'b1, 1'b0);
        checkOutput("basic_count", 64'(obs_q.size()), 64'(8));
        if (obs_q.size() == 8) begin
            checkOutput("basic_first", 64'(obs_q[0].data), 64'h10);
            checkOutput("basic_fourth", 64'(obs_q[3].data), 64'h13);
            checkOutput("basic_last_data", 64'(obs_q[7].data), 64'h17);
            checkOutput("basic_last_flag", 64'(obs_q[7].last), 64'(LAST_ON));
            checkOutput("basic_not_last", 64'(obs_q[6].last), 64'(0));
        end

        obs_q.delete();
        applyStimulus(WA'(15), WC'(2), 1'b1, 1'b0);
        checkOutput("wrap_count", 64'(obs_q.size()), 64'(16));
        if (obs_q.size() == 16) begin
            checkOutput("wrap_addr0", 64'(obs_q[0].addr), 64'(15));
            checkOutput("wrap_addr1", 64'(obs_q[8].addr), 64'(0));
            checkOutput("wrap_data0", 64'(obs_q[0].data), 64'hF0);
            checkOutput("wrap_data8", 64'(obs_q[8].data), 64'hA0);
            checkOutput("wrap_data15", 64'(obs_q[15].data), 64'hA7);
        end

        ready_mode = 1;
        applyStimulus(WA'(5), WC'(2), 1'b0, 1'b0);
        ready_mode = 0;

        applyStimulus(WA'(7), WC'(0), 1'b1, 1'b0);
        applyStimulus(WA'(2), WC'(2), 1'b1, 1'b1);
        applyStimulus(WA'(14), WC'(18), 1'b1, 1'b0);

        resetMidBurst();
        applyStimulus(WA'(6), WC'(1), 1'b1, 1'b0);

        for (int t = 0; t < 25; t++) begin
            ready_mode = $urandom_range(0, 2);
            applyStimulus(WA'($urandom_range(0, ENTRIES - 1)), WC'($urandom_range(0, 20)),
                          ready_mode == 0, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file_reader.md
REG_FILE_READER -- requirements
Module: reg_file_reader

Interface
REQ-001 SHALL have parameter WIDTH_ADDR, default 4, register-file address width.
REQ-002 SHALL have parameter WIDTH_VECTOR, default 8, elements per register-file entry.
REQ-003 SHALL have parameter N, default 32, bits per element.
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port start  input  1  request a burst read; sampled only in IDLE.
REQ-007 SHALL have port base_addr  input  WIDTH_ADDR  first entry address, captured with start.
REQ-008 SHALL have port count  input  WIDTH_ADDR+1  number of entries to read, captured with start.
REQ-009 SHALL have port rd_addr  output  WIDTH_ADDR  address to the register-file read port.
REQ-010 SHALL have port rd_data  input  WIDTH_VECTOR*N  combinational read data for rd_addr, same cycle.
REQ-011 SHALL have port m_data  output  N  streamed element.
REQ-012 SHALL have port m_valid  output  1  m_data is valid.
REQ-013 SHALL have port m_ready  input  1  downstream accepts; a transfer occurs when m_valid and m_ready are both 1.
REQ-014 SHALL have port m_last  output  1  final element of the burst (see Configuration).
REQ-015 SHALL have port busy  output  1  burst in progress.
REQ-016 SHALL have port done  output  1  one-cycle pulse at burst end.

Function
REQ-017 SHALL implement states IDLE, LOAD, SHIFT, FIN.
REQ-018 In IDLE, start=1 with count!=0 SHALL capture base_addr and count, set busy=1, and go to LOAD.
REQ-019 In IDLE, start=1 with count=0 SHALL go to FIN with no read and no m_valid.
REQ-020 In LOAD, the block SHALL drive rd_addr with the current entry address, register rd_data into a shift buffer, clear the element index, and go to SHIFT.
REQ-021 In SHIFT, m_valid SHALL be 1 and m_data SHALL equal element index i, bits [i*N +: N], starting at element 0.
REQ-022 While m_valid=1 and m_ready=0, m_data, m_last and the index SHALL hold stable.
REQ-023 On each transfer the index SHALL advance by one.
REQ-024 On the transfer of element WIDTH_VECTOR-1, the block SHALL decrement the remaining count and increment the entry address modulo 2**WIDTH_ADDR (wrap from max to 0).
REQ-025 After that transfer, the block SHALL go to LOAD if entries remain, else to FIN.
REQ-026 Latency SHALL be: start accepted at cycle T, LOAD at T+1, first m_valid at T+2, and one bubble cycle (LOAD) between entries.
REQ-027 FIN SHALL assert done for exactly one cycle, clear busy, and return to IDLE.
REQ-028 start SHALL be ignored while busy=1 or in FIN.
REQ-029 count values above 2**WIDTH_ADDR SHALL re-read entries after address wrap; no error is flagged.
REQ-030 rd_addr SHALL hold the last driven address outside LOAD.

Reset
REQ-031 rst=1 SHALL asynchronously force IDLE, m_valid=0, m_data=0, m_last=0, busy=0, done=0, rd_addr=0, index=0, remaining count=0.
REQ-032 Reset asserted mid-burst SHALL abandon the burst without a done pulse; after release the block SHALL wait for a new start.

Configuration
REQ-033 With macro REG_FILE_READER_LAST_EN defined, m_last SHALL be 1 exactly while m_valid=1 on element WIDTH_VECTOR-1 of the final entry.
REQ-034 Without REG_FILE_READER_LAST_EN, m_last SHALL be constant 0 and no last-detection logic SHALL be built.

Verification
REQ-035 Basic: base_addr=3, count=1, m_ready=1, entry 3 holding elements 0..7 = 0x10..0x17 -> m_data 0x10..0x17 on cycles T+2..T+9, done at T+10, m_last with element 0x17 (macro on).
REQ-036 Wrap: WIDTH_ADDR=4, base_addr=15, count=2 -> rd_addr 15 then 0; 16 elements streamed in order, with one bubble between entries.
REQ-037 Backpressure: m_ready toggles 1,0,0,1 on every element -> no element is lost or duplicated, and m_data is stable during stalls.
REQ-038 Zero count: start with count=0 -> no m_valid, and done pulses at T+1.
REQ-039 Start while busy: second start mid-burst with a different base_addr -> ignored; the original burst completes unchanged.
REQ-040 Reset mid-burst: rst asserted on element 4 of entry 0 -> all outputs are 0 at once, no done; a new start after release runs a correct burst.
